// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ID/EX control bundle and branch-condition helper.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;
   localparam logic [2:0] ALU_SLL = 3'd6;
   localparam logic [2:0] ALU_SRL = 3'd7;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} immsrc_e;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       alusrc;
      logic [1:0] resultsrc;
   } idex_ctrl_t;

   function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub);
      case (funct3)
         3'b000:         return sub ? ALU_SUB : ALU_ADD;
         3'b001:         return ALU_SLL;
         3'b010, 3'b011: return ALU_SLT;
         3'b100:         return ALU_XOR;
         3'b101:         return ALU_SRL;
         3'b110:         return ALU_OR;
         default:        return ALU_AND;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                         input logic lt, input logic ltu);
      case (funct3)
         F3_BEQ:  return zero;
         F3_BNE:  return !zero;
         F3_BLT:  return lt;
         F3_BGE:  return !lt;
         F3_BLTU: return ltu;
         F3_BGEU: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file; x0 reads zero and same-cycle WB writes are forwarded to the read ports.
module regfile_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr1,
   input  logic [ADDR_WIDTH-1:0] i_raddr2,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   output logic [DATA_WIDTH-1:0] o_rdata2
);
   localparam int NREGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [DATA_WIDTH-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (i_we && (i_waddr != '0)) regs_d[i_waddr] = i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // A nonzero read address matching the write address implies the write is not to x0.
   assign o_rdata1 = (i_raddr1 == '0) ? '0 :
                     (i_we && (i_waddr == i_raddr1)) ? i_wdata : regs_q[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? '0 :
                     (i_we && (i_waddr == i_raddr2)) ? i_wdata : regs_q[i_raddr2];

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: control/immediate decode, register read and the ID/EX register
// with hold, flush, load-use bubble insertion and branch resolution for the fetch PC mux.
module decode_stage_pipe
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int PC_WIDTH      = 10,
   parameter int ALUCTRL_WIDTH = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid_d,
   input  logic                     i_hold_e,
   input  logic                     i_flush_e,
   input  logic [DATA_WIDTH-1:0]    i_instr_d,
   input  logic [PC_WIDTH-1:0]      i_pc_d,
   input  logic [PC_WIDTH-1:0]      i_pc4_d,
   input  logic                     i_reg_write_w,
   input  logic [ADDR_WIDTH-1:0]    i_rd_addr_w,
   input  logic [DATA_WIDTH-1:0]    i_result_w,
   input  logic                     i_zero_e,
   input  logic                     i_lt_e,
   input  logic                     i_ltu_e,
   output logic                     o_valid_e,
   output logic                     o_regwrite_e,
   output logic                     o_memwrite_e,
   output logic                     o_jump_e,
   output logic                     o_branch_e,
   output logic                     o_alusrc_e,
   output logic [1:0]               o_resultsrc_e,
   output logic [ALUCTRL_WIDTH-1:0] o_aluctrl_e,
   output logic [2:0]               o_funct3_e,
   output logic [DATA_WIDTH-1:0]    o_rs1_data_e,
   output logic [DATA_WIDTH-1:0]    o_rs2_data_e,
   output logic [DATA_WIDTH-1:0]    o_immext_e,
   output logic [ADDR_WIDTH-1:0]    o_rs1_addr_e,
   output logic [ADDR_WIDTH-1:0]    o_rs2_addr_e,
   output logic [ADDR_WIDTH-1:0]    o_rd_addr_e,
   output logic [PC_WIDTH-1:0]      o_pc_e,
   output logic [PC_WIDTH-1:0]      o_pc4_e,
   output logic                     o_load_use_stall_d,
   output logic                     o_pcsrc_e
);
   logic [6:0]            id_opcode;
   logic [2:0]            id_funct3;
   logic [ADDR_WIDTH-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [DATA_WIDTH-1:0] id_rs1_data, id_rs2_data, id_immext;
   logic [31:0]           id_imm32;
   idex_ctrl_t            id_ctrl;
   logic [2:0]            id_alu;
   immsrc_e               id_immsrc;
   logic                  id_uses_rs1, id_uses_rs2;
   logic                  load_use;

   logic                     valid_q, valid_d;
   idex_ctrl_t               ctrl_q, ctrl_d;
   logic [ALUCTRL_WIDTH-1:0] aluctrl_q, aluctrl_d;
   logic [2:0]               funct3_q, funct3_d;
   logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, immext_q, immext_d;
   logic [ADDR_WIDTH-1:0]    rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d, pc4_q, pc4_d;

   assign id_opcode   = i_instr_d[6:0];
   assign id_funct3   = i_instr_d[14:12];
   assign id_rd_addr  = i_instr_d[7 +: ADDR_WIDTH];
   assign id_rs1_addr = i_instr_d[15 +: ADDR_WIDTH];
   assign id_rs2_addr = i_instr_d[20 +: ADDR_WIDTH];

   regfile_bypass #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_regfile (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (i_reg_write_w),
      .i_waddr  (i_rd_addr_w),
      .i_wdata  (i_result_w),
      .i_raddr1 (id_rs1_addr),
      .i_raddr2 (id_rs2_addr),
      .o_rdata1 (id_rs1_data),
      .o_rdata2 (id_rs2_data)
   );

   always_comb begin : controller
      id_ctrl   = '0;
      id_alu    = ALU_ADD;
      id_immsrc = IMM_NONE;
      case (id_opcode)
         OP_R: begin
            id_ctrl.regwrite = 1'b1;
            id_alu           = alu_decode(id_funct3, i_instr_d[30]);
         end
         OP_I: begin
            id_ctrl.regwrite = 1'b1;
            id_ctrl.alusrc   = 1'b1;
            id_immsrc        = IMM_I;
            id_alu           = alu_decode(id_funct3, 1'b0);
         end
         OP_LOAD: begin
            id_ctrl.regwrite  = 1'b1;
            id_ctrl.alusrc    = 1'b1;
            id_ctrl.resultsrc = RES_MEM;
            id_immsrc         = IMM_I;
         end
         OP_STORE: begin
            id_ctrl.memwrite = 1'b1;
            id_ctrl.alusrc   = 1'b1;
            id_immsrc        = IMM_S;
         end
         OP_BRANCH: begin
            id_ctrl.branch = 1'b1;
            id_immsrc      = IMM_B;
            id_alu         = ALU_SUB;
         end
         OP_JAL: begin
            id_ctrl.regwrite  = 1'b1;
            id_ctrl.jump      = 1'b1;
            id_ctrl.resultsrc = RES_PC4;
            id_immsrc         = IMM_J;
         end
         OP_JALR: begin
            id_ctrl.regwrite  = 1'b1;
            id_ctrl.jump      = 1'b1;
            id_ctrl.alusrc    = 1'b1;
            id_ctrl.resultsrc = RES_PC4;
            id_immsrc         = IMM_I;
         end
         OP_LUI, OP_AUIPC: begin
            id_ctrl.regwrite = 1'b1;
            id_ctrl.alusrc   = 1'b1;
            id_immsrc        = IMM_U;
         end
         default: ;
      endcase
   end

   always_comb begin : extend
      case (id_immsrc)
         IMM_I:   id_imm32 = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
         IMM_S:   id_imm32 = {{20{i_instr_d[31]}}, i_instr_d[31:25], i_instr_d[11:7]};
         IMM_B:   id_imm32 = {{20{i_instr_d[31]}}, i_instr_d[7], i_instr_d[30:25],
                              i_instr_d[11:8], 1'b0};
         IMM_J:   id_imm32 = {{12{i_instr_d[31]}}, i_instr_d[19:12], i_instr_d[20],
                              i_instr_d[30:21], 1'b0};
         IMM_U:   id_imm32 = {i_instr_d[31:12], 12'b0};
         default: id_imm32 = '0;
      endcase
   end
   assign id_immext = DATA_WIDTH'(id_imm32);

   assign id_uses_rs1 = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign id_uses_rs2 = id_opcode inside {OP_R, OP_STORE, OP_BRANCH};

   assign load_use = i_valid_d && valid_q && (ctrl_q.resultsrc == RES_MEM) && (rd_addr_q != '0) &&
                     ((id_uses_rs1 && (rd_addr_q == id_rs1_addr)) ||
                      (id_uses_rs2 && (rd_addr_q == id_rs2_addr)));

   // Flush beats hold; hold beats the load-use bubble so a frozen EX keeps its instruction.
   always_comb begin : idex_next
      valid_d    = valid_q;
      ctrl_d     = ctrl_q;
      aluctrl_d  = aluctrl_q;
      funct3_d   = funct3_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      immext_d   = immext_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      pc_d       = pc_q;
      pc4_d      = pc4_q;
      if (i_flush_e || (!i_hold_e && load_use)) begin
         valid_d    = 1'b0;
         ctrl_d     = '0;
         aluctrl_d  = '0;
         funct3_d   = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         immext_d   = '0;
         rs1_addr_d = '0;
         rs2_addr_d = '0;
         rd_addr_d  = '0;
         pc_d       = '0;
         pc4_d      = '0;
      end else if (!i_hold_e) begin
         valid_d    = i_valid_d;
         ctrl_d     = i_valid_d ? id_ctrl : '0;
         aluctrl_d  = i_valid_d ? ALUCTRL_WIDTH'(id_alu) : '0;
         funct3_d   = id_funct3;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         immext_d   = id_immext;
         rs1_addr_d = id_rs1_addr;
         rs2_addr_d = id_rs2_addr;
         rd_addr_d  = id_rd_addr;
         pc_d       = i_pc_d;
         pc4_d      = i_pc4_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         ctrl_q     <= '0;
         aluctrl_q  <= '0;
         funct3_q   <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         immext_q   <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         pc_q       <= '0;
         pc4_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         ctrl_q     <= ctrl_d;
         aluctrl_q  <= aluctrl_d;
         funct3_q   <= funct3_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         immext_q   <= immext_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         pc_q       <= pc_d;
         pc4_q      <= pc4_d;
      end
   end

   assign o_valid_e          = valid_q;
   assign o_regwrite_e       = ctrl_q.regwrite;
   assign o_memwrite_e       = ctrl_q.memwrite;
   assign o_jump_e           = ctrl_q.jump;
   assign o_branch_e         = ctrl_q.branch;
   assign o_alusrc_e         = ctrl_q.alusrc;
   assign o_resultsrc_e      = ctrl_q.resultsrc;
   assign o_aluctrl_e        = aluctrl_q;
   assign o_funct3_e         = funct3_q;
   assign o_rs1_data_e       = rs1_data_q;
   assign o_rs2_data_e       = rs2_data_q;
   assign o_immext_e         = immext_q;
   assign o_rs1_addr_e       = rs1_addr_q;
   assign o_rs2_addr_e       = rs2_addr_q;
   assign o_rd_addr_e        = rd_addr_q;
   assign o_pc_e             = pc_q;
   assign o_pc4_e            = pc4_q;
   assign o_load_use_stall_d = load_use;
   assign o_pcsrc_e          = valid_q &
                               ((ctrl_q.branch & branch_taken(funct3_q, i_zero_e, i_lt_e, i_ltu_e)) |
                                ctrl_q.jump);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Random and directed stimulus against a queue-based reference model of the decode stage.
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_d = 1'b0, hold_e = 1'b0, flush_e = 1'b0;
   logic [31:0] instr_d = '0;
   logic [9:0]  pc_d = '0, pc4_d = '0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_dat = '0;
   logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;

   logic        o_valid_e, o_regwrite_e, o_memwrite_e, o_jump_e, o_branch_e, o_alusrc_e;
   logic [1:0]  o_resultsrc_e;
   logic [2:0]  o_aluctrl_e, o_funct3_e;
   logic [31:0] o_rs1_data_e, o_rs2_data_e, o_immext_e;
   logic [4:0]  o_rs1_addr_e, o_rs2_addr_e, o_rd_addr_e;
   logic [9:0]  o_pc_e, o_pc4_e;
   logic        o_load_use_stall_d, o_pcsrc_e;

   always #5 clk = ~clk;

   decode_stage_pipe dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d), .i_hold_e(hold_e), .i_flush_e(flush_e),
      .i_instr_d(instr_d), .i_pc_d(pc_d), .i_pc4_d(pc4_d),
      .i_reg_write_w(wb_we), .i_rd_addr_w(wb_rd), .i_result_w(wb_dat),
      .i_zero_e(zero_e), .i_lt_e(lt_e), .i_ltu_e(ltu_e),
      .o_valid_e(o_valid_e), .o_regwrite_e(o_regwrite_e), .o_memwrite_e(o_memwrite_e),
      .o_jump_e(o_jump_e), .o_branch_e(o_branch_e), .o_alusrc_e(o_alusrc_e),
      .o_resultsrc_e(o_resultsrc_e), .o_aluctrl_e(o_aluctrl_e), .o_funct3_e(o_funct3_e),
      .o_rs1_data_e(o_rs1_data_e), .o_rs2_data_e(o_rs2_data_e), .o_immext_e(o_immext_e),
      .o_rs1_addr_e(o_rs1_addr_e), .o_rs2_addr_e(o_rs2_addr_e), .o_rd_addr_e(o_rd_addr_e),
      .o_pc_e(o_pc_e), .o_pc4_e(o_pc4_e),
      .o_load_use_stall_d(o_load_use_stall_d), .o_pcsrc_e(o_pcsrc_e)
   );

   typedef struct {
      bit        valid, regwrite, memwrite, jump, branch, alusrc;
      bit [1:0]  resultsrc;
      bit [2:0]  funct3;
      bit [31:0] rs1_data, rs2_data, imm;
      bit [4:0]  rs1a, rs2a, rda;
      bit [9:0]  pc, pc4;
   } est_t;
   typedef struct { bit stall, pcsrc; } cst_t;

   est_t      reg_q[$];
   cst_t      comb_q[$];
   est_t      m_e;
   bit [31:0] m_rf [32];
   bit        last_stall = 1'b0, last_hold = 1'b0;
   int        n_cmp = 0, n_bad = 0;

   localparam bit [31:0] NOP = 32'h0000_0013;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] m_imm(input bit [31:0] ins);
      bit signed [31:0] s = ins;
      case (ins[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
         7'b0100011: return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
         7'b1100011: return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                            (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         7'b1101111: return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                            (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
         7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a, input bit we, input bit [4:0] wa,
                                        input bit [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wa == a) return wd;
      return m_rf[a];
   endfunction

   // One D-stage cycle: drive, predict combinational outputs now and the ID/EX contents after the edge.
   task automatic step(input bit [31:0] ins, input bit vd, input bit hold, input bit flush,
                       input bit wwe, input bit [4:0] wrd, input bit [31:0] wdat,
                       input bit z, input bit lt, input bit ltu);
      est_t     nxt;
      cst_t     c;
      bit [6:0] op;
      bit       u1, u2, cond;
      @(negedge clk);
      rst_n = 1'b1;
      instr_d = ins; valid_d = vd; hold_e = hold; flush_e = flush;
      wb_we = wwe; wb_rd = wrd; wb_dat = wdat; zero_e = z; lt_e = lt; ltu_e = ltu;
      pc_d = 10'($urandom); pc4_d = pc_d + 10'd4;
      #1;
      op = ins[6:0];
      u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
      c.stall = vd && m_e.valid && m_e.resultsrc == 2'b01 && m_e.rda != 0 &&
                ((u1 && m_e.rda == ins[19:15]) || (u2 && m_e.rda == ins[24:20]));
      case (m_e.funct3)
         3'b000: cond = z;    3'b001: cond = !z;
         3'b100: cond = lt;   3'b101: cond = !lt;
         3'b110: cond = ltu;  3'b111: cond = !ltu;
         default: cond = 1'b0;
      endcase
      c.pcsrc = m_e.valid && ((m_e.branch && cond) || m_e.jump);
      comb_q.push_back(c);
      nxt = '{default: 0};
      if (!flush && hold) begin
         nxt = m_e;
      end else if (!flush && !c.stall) begin
         nxt.valid = vd;
         if (vd) begin
            case (op)
               7'b0110011: nxt.regwrite = 1;
               7'b0010011, 7'b0110111, 7'b0010111: begin nxt.regwrite = 1; nxt.alusrc = 1; end
               7'b0000011: begin nxt.regwrite = 1; nxt.alusrc = 1; nxt.resultsrc = 2'b01; end
               7'b0100011: begin nxt.memwrite = 1; nxt.alusrc = 1; end
               7'b1100011: nxt.branch = 1;
               7'b1101111: begin nxt.regwrite = 1; nxt.jump = 1; nxt.resultsrc = 2'b10; end
               7'b1100111: begin nxt.regwrite = 1; nxt.jump = 1; nxt.alusrc = 1;
                                 nxt.resultsrc = 2'b10; end
               default: ;
            endcase
         end
         nxt.funct3   = ins[14:12];
         nxt.rs1a     = ins[19:15];
         nxt.rs2a     = ins[24:20];
         nxt.rda      = ins[11:7];
         nxt.rs1_data = m_read(ins[19:15], wwe, wrd, wdat);
         nxt.rs2_data = m_read(ins[24:20], wwe, wrd, wdat);
         nxt.imm      = m_imm(ins);
         nxt.pc       = pc_d;
         nxt.pc4      = pc4_d;
      end
      reg_q.push_back(nxt);
      m_e = nxt;
      if (wwe && wrd != 0) m_rf[wrd] = wdat;
      last_stall = c.stall;
      last_hold  = hold;
   endtask

   task automatic sn(input bit [31:0] ins);
      step(ins, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic bit [31:0] rand_instr();
      bit [6:0]  ops [11];
      bit [31:0] r = $urandom;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0000011;
      ops[4] = 7'b0100011; ops[5] = 7'b1100011; ops[6] = 7'b1101111; ops[7] = 7'b1100111;
      ops[8] = 7'b0110111; ops[9] = 7'b0010111; ops[10] = 7'b0000000;
      r[6:0]   = ops[$urandom_range(0, 10)];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      return r;
   endfunction

   task automatic random_phase(input int n);
      bit [31:0] cur = NOP;
      bit        cur_v = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (!(last_stall || last_hold)) begin
            cur   = rand_instr();
            cur_v = ($urandom_range(0, 9) != 0);
         end
         step(cur, cur_v, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_ctrl"}, 32'({o_valid_e, o_regwrite_e, o_memwrite_e, o_jump_e, o_branch_e,
                              o_alusrc_e, o_resultsrc_e, o_aluctrl_e, o_funct3_e}), 32'd0);
      chk({nm, "_data"}, o_rs1_data_e | o_rs2_data_e | o_immext_e, 32'd0);
      chk({nm, "_addr"}, 32'({o_rs1_addr_e, o_rs2_addr_e, o_rd_addr_e, o_pc_e, o_pc4_e}), 32'd0);
      chk({nm, "_stall"}, o_load_use_stall_d, 0);
      chk({nm, "_pcsrc"}, o_pcsrc_e, 0);
   endtask

   // Combinational outputs, sampled mid-way through the D cycle.
   initial begin : comb_monitor
      cst_t c;
      forever begin
         @(negedge clk); #3;
         if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            chk("stall", o_load_use_stall_d, c.stall);
            chk("pcsrc", o_pcsrc_e, c.pcsrc);
         end
      end
   end

   // Registered ID/EX contents, sampled just after each rising edge.
   initial begin : reg_monitor
      est_t e;
      forever begin
         @(posedge clk); #1;
         if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            chk("valid", o_valid_e, e.valid);
            chk("regwrite", o_regwrite_e, e.regwrite);
            chk("memwrite", o_memwrite_e, e.memwrite);
            chk("jump", o_jump_e, e.jump);
            chk("branch", o_branch_e, e.branch);
            chk("alusrc", o_alusrc_e, e.alusrc);
            chk("resultsrc", o_resultsrc_e, e.resultsrc);
            chk("funct3", o_funct3_e, e.funct3);
            chk("rs1_data", o_rs1_data_e, e.rs1_data);
            chk("rs2_data", o_rs2_data_e, e.rs2_data);
            chk("immext", o_immext_e, e.imm);
            chk("addrs", {o_rs1_addr_e, o_rs2_addr_e, o_rd_addr_e}, {e.rs1a, e.rs2a, e.rda});
            chk("pcs", {o_pc_e, o_pc4_e}, {e.pc, e.pc4});
         end
      end
   end

   initial begin : driver
      m_e = '{default: 0};
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      #2;
      check_all_zero("reset");

      // lw x5,0(x1) then add x6,x5,x2: one stall cycle, bubble, then add enters
      sn({12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011});
      sn({7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011});
      chk("lu_stall", o_load_use_stall_d, 1);
      sn({7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011});
      chk("lu_bubble_valid", o_valid_e, 0);
      chk("lu_bubble_regwrite", o_regwrite_e, 0);
      sn(NOP);
      chk("lu_add_rs1", o_rs1_addr_e, 5);
      chk("lu_add_valid", o_valid_e, 1);

      // lw x0 then use of x0; lw x5 then lui x5 (rs fields = 5 but unused)
      sn({12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011});
      sn({7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011});
      chk("lw_x0_nostall", o_load_use_stall_d, 0);
      sn({12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011});
      sn({7'd0, 5'd5, 5'd5, 3'b000, 5'd5, 7'b0110111});
      chk("lui_nostall", o_load_use_stall_d, 0);

      // Write-through bypass and x0 write suppression
      step({7'd0, 5'd0, 5'd3, 3'b000, 5'd7, 7'b0110011}, 1, 0, 0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
      sn(NOP);
      chk("bypass_x3", o_rs1_data_e, 32'hDEADBEEF);
      step({7'd0, 5'd0, 5'd0, 3'b000, 5'd7, 7'b0110011}, 1, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 0);
      sn(NOP);
      chk("x0_stays_0", o_rs1_data_e, 0);

      // Branch resolution
      sn({7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011});
      step(NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("bne_taken", o_pcsrc_e, 1);
      sn({7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011});
      step(NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("bltu_not_taken", o_pcsrc_e, 0);
      sn({7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011});
      step(NOP, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("blt_taken", o_pcsrc_e, 1);
      step({7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("bne_invalid", o_pcsrc_e, 0);

      // Hold for three edges, then hold+flush loads a bubble
      sn({7'd0, 5'd2, 5'd1, 3'b000, 5'd6, 7'b0110011});
      for (int i = 0; i < 3; i++) begin
         step({12'd1, 5'd1, 3'b000, 5'd9, 7'b0010011}, 1, 1, 0, 0, 0, 0, 0, 0, 0);
         chk("hold_rd", o_rd_addr_e, 6);
      end
      step({12'd1, 5'd1, 3'b000, 5'd9, 7'b0010011}, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("hold_rd_last", o_rd_addr_e, 6);
      sn(NOP);
      chk("flush_hold_bubble", o_valid_e, 0);

      random_phase(600);

      // Asynchronous reset in the middle of traffic
      @(negedge clk);
      zero_e = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      m_e = '{default: 0};
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      last_stall = 1'b0; last_hold = 1'b0;
      sn({7'd0, 5'd2, 5'd1, 3'b000, 5'd6, 7'b0110011});
      sn(NOP);
      chk("post_reset_load", {o_valid_e, o_rd_addr_e}, {1'b1, 5'd6});

      random_phase(100);

      @(negedge clk); @(negedge clk); #4;
      chk("drain", comb_q.size() + reg_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised next-generation instruction decode stage for the RV32I pipelined core. It decodes the D-stage instruction, reads operands through a write-through register file, and extends immediates. It also owns the ID/EX pipeline register, adding valid tracking, hold and bubble control, load-use hazard detection, and full six-way branch-condition resolution for the fetch PC mux.

Parameters:
DATA_WIDTH, 32, register and immediate width
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
PC_WIDTH, 10, instruction-memory PC width
ALUCTRL_WIDTH, 3, width of ALU control field

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_valid_d  in  1  IF/ID register holds a real instruction
i_hold_e  in  1  downstream stall: ID/EX register keeps its contents
i_flush_e  in  1  squash: ID/EX register loads a bubble
i_instr_d  in  DATA_WIDTH  instruction word
i_pc_d  in  PC_WIDTH  instruction PC
i_pc4_d  in  PC_WIDTH  PC+4
i_reg_write_w  in  1  WB write enable
i_rd_addr_w  in  ADDR_WIDTH  WB destination
i_result_w  in  DATA_WIDTH  WB data
i_zero_e, i_lt_e, i_ltu_e  in  1 each  EX comparison flags (rs1==rs2, signed <, unsigned <)
o_valid_e  out  1  ID/EX holds a real instruction
o_regwrite_e, o_memwrite_e, o_jump_e, o_branch_e, o_alusrc_e  out  1 each  registered controls
o_resultsrc_e  out  2  registered result select (2'b01 = load)
o_aluctrl_e  out  ALUCTRL_WIDTH  registered ALU control
o_funct3_e  out  3  registered funct3
o_rs1_data_e, o_rs2_data_e, o_immext_e  out  DATA_WIDTH  registered operands and immediate
o_rs1_addr_e, o_rs2_addr_e, o_rd_addr_e  out  ADDR_WIDTH  registered register addresses
o_pc_e, o_pc4_e  out  PC_WIDTH  registered PC and PC+4
o_load_use_stall_d  out  1  freeze PC and IF/ID; this block inserts the bubble
o_pcsrc_e  out  1  take branch or jump target

Behaviour:
- Reset: i_rst_n and i_clk as decided: asynchronous, active-low reset; clock i_clk. All registered outputs reset to 0. Register file contents reset to 0.
- Flush is synchronous only. It is never part of the asynchronous sensitivity.
- ID/EX update priority on each rising edge:
  1. i_flush_e: load a bubble.
  2. i_hold_e: keep all contents.
  3. o_load_use_stall_d: load a bubble.
  4. Otherwise: load the D-stage values, with o_valid_e <= i_valid_d.
- Bubble definition: valid, regwrite, memwrite, jump and branch are 0. Data and address fields are don't-care; the implementation drives them to 0.
- A D-stage instruction with i_valid_d=0 forces all registered control enables to 0.
- Control and immediate generation reuse the existing controller and extend modules unchanged. Latency from D to E is 1 cycle.
- Register reads:
  - x0 always reads 0.
  - Write-through bypass: if i_reg_write_w, i_rd_addr_w!=0 and i_rd_addr_w equals the read address, the read returns i_result_w in the same cycle.
  - Writes to x0 are ignored.
- Operand-use decode (from the opcode):
  - uses_rs1 is false for lui (0110111), auipc (0010111) and jal (1101111), and true otherwise.
  - uses_rs2 is true only for R-type (0110011), store (0100011) and branch (1100011).
- Load-use detection is combinational. o_load_use_stall_d is asserted when all of the following hold:
  - i_valid_d and o_valid_e are 1;
  - o_resultsrc_e==2'b01 and o_rd_addr_e!=0;
  - either (uses_rs1 and o_rd_addr_e==rs1_d) or (uses_rs2 and o_rd_addr_e==rs2_d).
- Load-use while held: if i_hold_e is 1, the stall output still asserts, but the register holds rather than bubbles.
- Branch condition from o_funct3_e:
  - 000: i_zero_e
  - 001: !i_zero_e
  - 100: i_lt_e
  - 101: !i_lt_e
  - 110: i_ltu_e
  - 111: !i_ltu_e
  - 010 and 011: 0
- o_pcsrc_e = o_valid_e & ((o_branch_e & cond) | o_jump_e).
- Simultaneous flush and load-use: flush wins, and the bubble is loaded. The stall output remains asserted that cycle.
- Reset mid-stream: all state clears immediately. The first post-reset edge loads the D stage normally.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC);
  - resultsrc constants (RES_ALU=00, RES_MEM=01, RES_PC4=10);
  - branch funct3 constants;
  - a packed struct idex_ctrl_t carrying the registered controls.
- One sub-module, regfile_bypass: the 2-read/1-write register file with x0 hardwiring and write-through.

Test Plan:
- Reset during traffic: all outputs are 0 asynchronously, and o_pcsrc_e=0 even with i_zero_e=1.
- lw x5,0(x1) followed by add x6,x5,x2: one cycle with o_load_use_stall_d=1, then o_valid_e=0 and o_regwrite_e=0. Next edge: add enters with o_rs1_addr_e=5.
- lw x0 followed by use of x0, and lw x5 followed by lui x5: no stall.
- WB writes x3=0xDEADBEEF while D reads x3: o_rs1_data_e=0xDEADBEEF the next cycle. WB writes to x0: x0 still reads 0.
- bne (funct3 001) with i_zero_e=0 gives o_pcsrc_e=1. bltu with i_ltu_e=0 gives 0. blt with i_lt_e=1 gives 1. The same bne with o_valid_e=0 gives 0.
- i_hold_e=1 for 3 cycles: all E outputs are unchanged. i_flush_e and i_hold_e together: bubble loaded.
